// File: rtl/fmac_rr_scheduler.sv
// rtl/fmac_rr_scheduler.sv - round-robin scheduler sharing one float MAC among NREQ requesters
// One op in flight: arbitrate, issue to MAC, wait for done or watchdog, respond to owner.
module fmac_rr_scheduler #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*32-1:0]   a_in,
  input  logic [NREQ*32-1:0]   b_in,
  input  logic [NREQ*32-1:0]   c_in,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_data,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 mac_start,
  output logic [31:0]          mac_a,
  output logic [31:0]          mac_b,
  output logic [31:0]          mac_c,
  input  logic                 mac_done,
  input  logic [31:0]          mac_result
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic            mac_start_q, mac_start_d;
  logic [31:0]     mac_a_q, mac_a_d;
  logic [31:0]     mac_b_q, mac_b_d;
  logic [31:0]     mac_c_q, mac_c_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [31:0]     a_arr [NREQ];
  logic [31:0]     b_arr [NREQ];
  logic [31:0]     c_arr [NREQ];
  logic [IW-1:0]   win_idx;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = a_in[32*i +: 32];
    assign b_arr[i] = b_in[32*i +: 32];
    assign c_arr[i] = c_in[32*i +: 32];
  end

  // Scan from farthest to nearest so the first set bit after 'last' wins.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [IW-1:0] last);
    logic [IW-1:0] pick;
    logic [IW-1:0] idx_w;
    int            idx;
    pick = last;
    for (int k = NREQ; k >= 1; k--) begin
      idx   = (int'(last) + k) % NREQ;
      idx_w = IW'(idx);
      if (r[idx_w]) pick = idx_w;
    end
    return pick;
  endfunction

  assign win_idx = rr_pick(req, last_q);

  always_comb begin
    state_d     = state_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    mac_start_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    mac_a_d     = mac_a_q;
    mac_b_d     = mac_b_q;
    mac_c_d     = mac_c_q;
    owner_d     = owner_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          owner_d          = win_idx;
          mac_a_d          = a_arr[win_idx];
          mac_b_d          = b_arr[win_idx];
          mac_c_d          = c_arr[win_idx];
          gnt_d[win_idx]   = 1'b1;
          mac_start_d      = 1'b1;
          state_d          = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving on the last watchdog cycle still delivers real data.
        if (mac_done) begin
          rsp_data_d           = mac_result;
          rsp_err_d            = 1'b0;
          rsp_valid_d[owner_q] = 1'b1;
          state_d              = S_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rsp_data_d           = QNAN;
          rsp_err_d            = 1'b1;
          rsp_valid_d[owner_q] = 1'b1;
          state_d              = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        last_d  = owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      mac_start_q <= 1'b0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      mac_c_q     <= '0;
      owner_q     <= '0;
      last_q      <= IW'(NREQ - 1);
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      mac_start_q <= mac_start_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      mac_c_q     <= mac_c_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign mac_start = mac_start_q;
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign mac_c     = mac_c_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_fmac_rr_scheduler.sv
// tb/tb_fmac_rr_scheduler.sv - self-checking bench for fmac_rr_scheduler
// Table vectors, randomized ops against a transaction-level model, and corner sequences.
module tb_fmac_rr_scheduler;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 24;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ*32-1:0]   a_in, b_in, c_in;
  logic [NREQ-1:0]      gnt, rsp_valid;
  logic [31:0]          rsp_data;
  logic                 rsp_err, busy, mac_start;
  logic [31:0]          mac_a, mac_b, mac_c;
  logic                 mac_done;
  logic [31:0]          mac_result;

  logic [31:0] op_a [NREQ];
  logic [31:0] op_b [NREQ];
  logic [31:0] op_c [NREQ];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   ref_last;
  int   mac_delay;
  logic force_done;
  int   mdl_cnt = 0;
  logic mdl_done = 1'b0;
  logic [31:0] mdl_res = '0;

  fmac_rr_scheduler #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .c_in(c_in),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .mac_start(mac_start), .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c),
    .mac_done(mac_done), .mac_result(mac_result)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      a_in[32*i +: 32] = op_a[i];
      b_in[32*i +: 32] = op_b[i];
      c_in[32*i +: 32] = op_c[i];
    end
  end

  // External MAC stand-in: 2*3+1 gives 7.0, anything else a fixed mix.
  function automatic logic [31:0] mac_f(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    if (a == 32'h4000_0000 && b == 32'h4040_0000 && c == 32'h3F80_0000) return 32'h40E0_0000;
    return (a ^ {b[15:0], b[31:16]}) + c;
  endfunction

  // MAC model deliberately ignores rst so an aborted op still produces a stray done.
  always @(posedge clk) begin
    mdl_done <= 1'b0;
    if (mac_start) begin
      mdl_res <= mac_f(mac_a, mac_b, mac_c);
      if (mac_delay == 1) mdl_done <= 1'b1;
      else if (mac_delay > 1) mdl_cnt <= mac_delay - 1;
    end else if (mdl_cnt != 0) begin
      mdl_cnt <= mdl_cnt - 1;
      if (mdl_cnt == 1) mdl_done <= 1'b1;
    end
  end

  assign mac_done   = mdl_done | force_done;
  assign mac_result = mdl_res;

  function automatic logic [NREQ-1:0] oh(input int i);
    return NREQ'(1) << i;
  endfunction

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v == oh(i)) return i;
    return -1;
  endfunction

  function automatic int rr_ref(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (((r >> ((last + k) % NREQ)) & NREQ'(1)) != 0) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Start in IDLE; leaves the DUT in the IDLE cycle following RESP.
  task automatic run_op(input logic [NREQ-1:0] r, input int d, input int w, input logic spur);
    int          lat;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_data;
    logic [31:0] prev;
    exp_err  = (d == 0) || (d > TIMEOUT);
    exp_lat  = exp_err ? TIMEOUT + 1 : d + 1;
    exp_data = exp_err ? QNAN : mac_f(op_a[w], op_b[w], op_c[w]);
    mac_delay = d;
    req = r;
    step();
    chk("issue_gnt", 32'(gnt), 32'(oh(w)));
    chk("issue_mac_start", 32'(mac_start), 32'd1);
    chk("issue_mac_a", mac_a, op_a[w]);
    chk("issue_mac_b", mac_b, op_b[w]);
    chk("issue_mac_c", mac_c, op_c[w]);
    req = NREQ'($urandom);
    lat = 0;
    while (rsp_valid == '0 && lat < TIMEOUT + 8) begin
      step();
      lat++;
      if (rsp_valid == '0) chk("wait_quiet", {27'd0, gnt, mac_start}, 32'd0);
      chk("wait_busy", 32'(busy), 32'd1);
    end
    chk("rsp_valid", 32'(rsp_valid), 32'(oh(w)));
    chk("rsp_latency", 32'(lat), 32'(exp_lat));
    chk("rsp_data", rsp_data, exp_data);
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    req = '0;
    force_done = spur;
    prev = rsp_data;
    step();
    force_done = 1'b0;
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_rsp_data_hold", rsp_data, prev);
    chk("post_rsp_err_hold", 32'(rsp_err), 32'(exp_err));
    ref_last = w;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_gnt"}, 32'(gnt), 32'd0);
    chk({nm, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({nm, "_rsp_data"}, rsp_data, 32'd0);
    chk({nm, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_mac_start"}, 32'(mac_start), 32'd0);
    chk({nm, "_mac_a"}, mac_a, 32'd0);
    chk({nm, "_mac_b"}, mac_b, 32'd0);
    chk({nm, "_mac_c"}, mac_c, 32'd0);
  endtask

  task automatic collect_grants(input logic [NREQ-1:0] r, input int n, output int got [$]);
    int cyc;
    got = {};
    req = r;
    cyc = 0;
    while (got.size() < n && cyc < 400) begin
      step();
      cyc++;
      chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      chk("rsp_onehot0", 32'($onehot0(rsp_valid)), 32'd1);
      if (gnt != '0) got.push_back(oh_idx(gnt));
    end
    chk("grant_count", 32'(got.size()), 32'(n));
  endtask

  typedef struct {
    logic [NREQ-1:0] r;
    int              d;
    int              w;
  } vec_t;

  vec_t tbl [8];
  int   grants [$];

  initial begin
    tbl[0] = '{4'b0001, 7, 0};
    tbl[1] = '{4'b1111, 3, 1};
    tbl[2] = '{4'b0011, 1, 0};
    tbl[3] = '{4'b1000, 0, 3};
    tbl[4] = '{4'b1010, TIMEOUT, 1};
    tbl[5] = '{4'b0110, 5, 2};
    tbl[6] = '{4'b0111, 2, 0};
    tbl[7] = '{4'b1001, TIMEOUT + 3, 3};

    rst = 1'b1;
    req = '0;
    force_done = 1'b0;
    mac_delay = 0;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = $urandom;
      op_b[i] = $urandom;
      op_c[i] = $urandom;
    end
    op_a[0] = 32'h4000_0000;
    op_b[0] = 32'h4040_0000;
    op_c[0] = 32'h3F80_0000;
    #2;
    chk_all_zero("reset");
    step();
    step();
    rst = 1'b0;
    ref_last = NREQ - 1;
    step();

    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].r, tbl[i].d, tbl[i].w, i == 5);
      if (i == 0) chk("single_op_data", rsp_data, 32'h40E0_0000);
    end

    // Spurious done while idle must not disturb anything.
    begin
      logic [31:0] prev;
      prev = rsp_data;
      force_done = 1'b1;
      step();
      force_done = 1'b0;
      chk("spur_idle_busy", 32'(busy), 32'd0);
      chk("spur_idle_rsp", 32'(rsp_valid), 32'd0);
      step();
      chk("spur_idle_data", rsp_data, prev);
      chk("spur_idle_rsp2", 32'(rsp_valid), 32'd0);
    end

    for (int n = 0; n < 40; n++) begin
      logic [NREQ-1:0] r;
      int d;
      for (int i = 0; i < NREQ; i++) begin
        op_a[i] = $urandom;
        op_b[i] = $urandom;
        op_c[i] = $urandom;
      end
      r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      d = $urandom_range(0, 9);
      run_op(r, d, rr_ref(r, ref_last), 1'b0);
    end

    // Reset three cycles after mac_start aborts the op; the later stray done is ignored.
    op_a[0] = 32'h4000_0000;
    op_b[0] = 32'h4040_0000;
    op_c[0] = 32'h3F80_0000;
    mac_delay = 7;
    req = 4'b0001;
    step();
    chk("rw_mac_start", 32'(mac_start), 32'd1);
    req = '0;
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    chk_all_zero("rst_wait");
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("rw_no_rsp", 32'(rsp_valid), 32'd0);
      chk("rw_idle", 32'(busy), 32'd0);
    end
    ref_last = NREQ - 1;
    run_op(4'b0001, 4, 0, 1'b0);

    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    mac_delay = 2;
    collect_grants(4'b1111, 8, grants);
    for (int i = 0; i < grants.size(); i++) chk("fair_order", 32'(grants[i]), 32'(i % NREQ));
    collect_grants(4'b1010, 4, grants);
    for (int i = 0; i < grants.size(); i++) chk("wrap_order", 32'(grants[i]), (i % 2 == 0) ? 32'd1 : 32'd3);
    req = '0;
    begin
      int cyc;
      cyc = 0;
      while (busy && cyc < TIMEOUT + 8) begin
        step();
        cyc++;
      end
      chk("drain_idle", 32'(busy), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
